// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: FSM states, parity modes
// and frame constants.
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_REQ    = 3'd1,
      ST_LOAD   = 3'd2,
      ST_START  = 3'd3,
      ST_DATA   = 3'd4,
      ST_PARITY = 3'd5,
      ST_STOP   = 3'd6
   } state_t;

   localparam int PAR_NONE  = 0;
   localparam int PAR_EVEN  = 1;
   localparam int PAR_ODD   = 2;
   localparam int DATA_BITS = 8;

   function automatic logic parity_bit(input logic [7:0] data, input int mode);
      return (mode == PAR_ODD) ? ~(^data) : ^data;
   endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and pulses tick on the last
// cycle of every bit period; clear holds the count at zero.
module uart_baud_tick #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   output logic tick
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_next;

   always_comb begin
      cnt_next = cnt + 1'b1;
      if (clear || cnt == LAST) cnt_next = '0;
   end

   // tick is registered against the next count so it lines up with cnt == LAST
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt  <= '0;
         tick <= 1'b0;
      end else begin
         cnt  <= cnt_next;
         tick <= (cnt_next == LAST);
      end
   end

endmodule

// File: rtl/uart_tx_fifo_drain.sv
// Drains bytes from the 16x8 FIFO and serialises each as a UART frame on tx:
// start bit, 8 data bits LSB first, optional parity, 1 or 2 stop bits.
module uart_tx_fifo_drain
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16,
   parameter int PARITY       = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tx_en,
   input  logic       fifo_empty,
   input  logic [7:0] fifo_data,
   output logic       fifo_rd,
   output logic       tx,
   output logic       busy,
   output logic       frame_done
);

   localparam logic STOP_LAST = (STOP_BITS == 2);

   state_t     state;
   logic [7:0] shift;
   logic       par_bit;
   logic [2:0] bit_idx;
   logic       stop_idx;
   logic       tick;
   logic       baud_clear;

   // Counter is held at zero until the frame proper begins in START.
   assign baud_clear = (state == ST_IDLE) || (state == ST_REQ) || (state == ST_LOAD);

   uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
      .clk   (clk),
      .reset (reset),
      .clear (baud_clear),
      .tick  (tick)
   );

   // Decoded from flops only (state, stop index, registered tick) so it lands
   // in the final stop cycle without a lookahead on the baud count.
   assign frame_done = (state == ST_STOP) && (stop_idx == STOP_LAST) && tick;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= ST_IDLE;
         shift    <= '0;
         par_bit  <= 1'b0;
         bit_idx  <= '0;
         stop_idx <= 1'b0;
         tx       <= 1'b1;
         fifo_rd  <= 1'b0;
         busy     <= 1'b0;
      end else begin
         fifo_rd <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               tx <= 1'b1;
               if (tx_en && !fifo_empty) begin
                  state   <= ST_REQ;
                  fifo_rd <= 1'b1;
                  busy    <= 1'b1;
               end
            end
            ST_REQ: state <= ST_LOAD;
            ST_LOAD: begin
               shift   <= fifo_data;
               par_bit <= parity_bit(fifo_data, PARITY);
               tx      <= 1'b0;
               state   <= ST_START;
            end
            ST_START: begin
               if (tick) begin
                  tx      <= shift[0];
                  bit_idx <= '0;
                  state   <= ST_DATA;
               end
            end
            ST_DATA: begin
               if (tick) begin
                  if (bit_idx == 3'(DATA_BITS - 1)) begin
                     stop_idx <= 1'b0;
                     if (PARITY != PAR_NONE) begin
                        tx    <= par_bit;
                        state <= ST_PARITY;
                     end else begin
                        tx    <= 1'b1;
                        state <= ST_STOP;
                     end
                  end else begin
                     shift   <= shift >> 1;
                     tx      <= shift[1];
                     bit_idx <= bit_idx + 1'b1;
                  end
               end
            end
            ST_PARITY: begin
               if (tick) begin
                  tx    <= 1'b1;
                  state <= ST_STOP;
               end
            end
            ST_STOP: begin
               if (tick) begin
                  if (stop_idx == STOP_LAST) begin
                     state <= ST_IDLE;
                     busy  <= 1'b0;
                  end else begin
                     stop_idx <= 1'b1;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// Bench for uart_tx_fifo_drain: three parameterisations driven from FIFO
// models and checked every cycle against a frame-timeline reference model.
module tb_uart_tx_fifo_drain;

   logic       clk = 1'b0;
   logic       reset;
   logic       tx_en;
   logic       fifo_empty [3];
   logic [7:0] fifo_data  [3];
   logic       fifo_rd    [3];
   logic       tx         [3];
   logic       busy       [3];
   logic       frame_done [3];

   always #5 clk = ~clk;

   uart_tx_fifo_drain #(.CLKS_PER_BIT(4), .PARITY(0), .STOP_BITS(1)) dut0 (
      .clk(clk), .reset(reset), .tx_en(tx_en), .fifo_empty(fifo_empty[0]),
      .fifo_data(fifo_data[0]), .fifo_rd(fifo_rd[0]), .tx(tx[0]),
      .busy(busy[0]), .frame_done(frame_done[0]));

   uart_tx_fifo_drain #(.CLKS_PER_BIT(4), .PARITY(1), .STOP_BITS(1)) dut1 (
      .clk(clk), .reset(reset), .tx_en(tx_en), .fifo_empty(fifo_empty[1]),
      .fifo_data(fifo_data[1]), .fifo_rd(fifo_rd[1]), .tx(tx[1]),
      .busy(busy[1]), .frame_done(frame_done[1]));

   uart_tx_fifo_drain #(.CLKS_PER_BIT(3), .PARITY(2), .STOP_BITS(2)) dut2 (
      .clk(clk), .reset(reset), .tx_en(tx_en), .fifo_empty(fifo_empty[2]),
      .fifo_data(fifo_data[2]), .fifo_rd(fifo_rd[2]), .tx(tx[2]),
      .busy(busy[2]), .frame_done(frame_done[2]));

   function automatic int nclk(int d);
      return (d == 2) ? 3 : 4;
   endfunction

   function automatic int par_of(int d);
      return d;
   endfunction

   function automatic int nstop(int d);
      return (d == 2) ? 2 : 1;
   endfunction

   function automatic int frame_bits(int d);
      return 10 + ((par_of(d) != 0) ? 1 : 0) + (nstop(d) - 1);
   endfunction

   // Frame as a bit list, index 0 first on the wire; unused tail stays high.
   function automatic logic [11:0] build(int d, logic [7:0] b);
      logic [11:0] f;
      f      = '1;
      f[0]   = 1'b0;
      f[8:1] = b;
      if (par_of(d) == 1) f[9] = (($countones(b) % 2) == 1);
      if (par_of(d) == 2) f[9] = (($countones(b) % 2) == 0);
      return f;
   endfunction

   int checks = 0;
   int errors = 0;
   int cyc_no = 0;

   logic [7:0] mem [3][64];
   int         wp [3];
   int         rp [3];
   bit         hold [3];
   int         rd_count [3];

   bit          m_busy [3];
   int          m_pos  [3];
   logic [11:0] m_bits [3];

   task automatic check(input string nm, input int got, input int want);
      checks++;
      if (got != want) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0h, want %0h", nm, cyc_no, got, want);
      end
   endtask

   task automatic push(input int d, input logic [7:0] b);
      mem[d][wp[d] % 64] = b;
      wp[d]++;
      fifo_empty[d] = 1'b0;
   endtask

   // Model time advances at the clock edge using the inputs the DUT sees there.
   task automatic model_step();
      for (int d = 0; d < 3; d++) begin
         if (reset) begin
            m_busy[d] = 1'b0;
         end else if (m_busy[d]) begin
            if (m_pos[d] == 1 + frame_bits(d) * nclk(d)) m_busy[d] = 1'b0;
            else m_pos[d]++;
         end else if (tx_en && !fifo_empty[d]) begin
            m_busy[d] = 1'b1;
            m_pos[d]  = 0;
            m_bits[d] = build(d, mem[d][rp[d] % 64]);
         end
      end
   endtask

   task automatic cyc();
      logic [3:0] exp_v;
      logic [3:0] got_v;
      logic       t;
      @(posedge clk);
      model_step();
      cyc_no++;
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
         if (!m_busy[d]) begin
            exp_v = 4'b1000;
         end else begin
            t = (m_pos[d] < 2) ? 1'b1 : m_bits[d][(m_pos[d] - 2) / nclk(d)];
            exp_v = {t, m_pos[d] == 0, 1'b1, m_pos[d] == 1 + frame_bits(d) * nclk(d)};
         end
         got_v = {tx[d], fifo_rd[d], busy[d], frame_done[d]};
         check($sformatf("model_dut%0d{tx,rd,busy,done}", d), int'(got_v), int'(exp_v));
         if (fifo_rd[d]) begin
            rd_count[d]++;
            if (wp[d] != rp[d]) begin
               fifo_data[d] = mem[d][rp[d] % 64];
               rp[d]++;
            end
            hold[d] = 1'b1;
         end else if (hold[d]) begin
            hold[d] = 1'b0;
         end else begin
            fifo_data[d] = 8'($urandom);
         end
         fifo_empty[d] = (wp[d] == rp[d]);
      end
   endtask

   // Returns captured mid-bit samples, falling-edge cycle and frame_done cycle.
   task automatic run_frame(input int d, output logic [11:0] got, output int fall_at,
                            output int done_at);
      int rel;
      got     = '0;
      fall_at = -1;
      done_at = -1;
      for (int k = 0; k < 400 && done_at < 0; k++) begin
         cyc();
         if (fall_at < 0 && tx[d] == 1'b0) fall_at = cyc_no;
         if (fall_at >= 0) begin
            rel = cyc_no - fall_at;
            if ((rel % nclk(d)) == nclk(d) / 2 && rel / nclk(d) < 12) got[rel / nclk(d)] = tx[d];
            if (frame_done[d]) done_at = cyc_no;
         end
      end
      check($sformatf("frame_seen_dut%0d", d), int'(done_at >= 0), 1);
   endtask

   typedef struct {
      int          d;
      logic [7:0]  b;
      logic [11:0] bits;
      int          nb;
      int          done_off;
   } vec_t;

   vec_t tbl [8];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [11:0] got;
      logic [11:0] msk;
      int          fall_a, done_a, fall_b, done_b, rdc, lat;
      bit          seen;
      bit          drained;

      tbl[0] = '{0, 8'hA5, 12'({1'b1, 8'hA5, 1'b0}), 10, 39};
      tbl[1] = '{0, 8'h00, 12'({1'b1, 8'h00, 1'b0}), 10, 39};
      tbl[2] = '{0, 8'hFF, 12'({1'b1, 8'hFF, 1'b0}), 10, 39};
      tbl[3] = '{1, 8'hA5, 12'({1'b1, 1'b0, 8'hA5, 1'b0}), 11, 43};
      tbl[4] = '{1, 8'h01, 12'({1'b1, 1'b1, 8'h01, 1'b0}), 11, 43};
      tbl[5] = '{1, 8'hFF, 12'({1'b1, 1'b0, 8'hFF, 1'b0}), 11, 43};
      tbl[6] = '{2, 8'hA5, {2'b11, 1'b1, 8'hA5, 1'b0}, 12, 35};
      tbl[7] = '{2, 8'h80, {2'b11, 1'b0, 8'h80, 1'b0}, 12, 35};

      reset = 1'b0;
      tx_en = 1'b0;
      for (int d = 0; d < 3; d++) begin
         fifo_empty[d] = 1'b1;
         fifo_data[d]  = '0;
         wp[d] = 0; rp[d] = 0; hold[d] = 1'b0; rd_count[d] = 0;
         m_busy[d] = 1'b0; m_pos[d] = 0; m_bits[d] = '1;
      end
      #1 reset = 1'b1;

      // Reset held with data available and tx_en high.
      push(0, 8'h3C);
      tx_en = 1'b1;
      repeat (3) cyc();
      reset = 1'b0;
      cyc();
      check("first_rd_after_reset", int'(fifo_rd[0]), 1);
      repeat (50) cyc();

      for (int i = 0; i < 8; i++) begin
         push(tbl[i].d, tbl[i].b);
         run_frame(tbl[i].d, got, fall_a, done_a);
         msk = 12'((1 << tbl[i].nb) - 1);
         check($sformatf("tbl%0d_bits", i), int'(got & msk), int'(tbl[i].bits));
         check($sformatf("tbl%0d_done_offset", i), done_a - fall_a, tbl[i].done_off);
         repeat (5) cyc();
      end

      // Back-to-back frames.
      rd_count[0] = 0;
      push(0, 8'h01);
      push(0, 8'h80);
      run_frame(0, got, fall_a, done_a);
      check("b2b_first_bits", int'(got & 12'h3FF), int'({1'b1, 8'h01, 1'b0}));
      run_frame(0, got, fall_b, done_b);
      check("b2b_second_bits", int'(got & 12'h3FF), int'({1'b1, 8'h80, 1'b0}));
      check("b2b_gap", fall_b - done_a, 4);
      repeat (20) cyc();
      check("b2b_read_count", rd_count[0], 2);

      // Flow control: drop tx_en during DATA of the first frame.
      push(0, 8'h11);
      push(0, 8'h22);
      push(0, 8'h33);
      fall_a = -1;
      for (int k = 0; k < 100 && fall_a < 0; k++) begin
         cyc();
         if (tx[0] == 1'b0) fall_a = cyc_no;
      end
      repeat (8) cyc();
      tx_en = 1'b0;
      rdc   = rd_count[0];
      seen  = 1'b0;
      for (int k = 0; k < 100 && !seen; k++) begin
         cyc();
         if (frame_done[0]) seen = 1'b1;
      end
      repeat (20) cyc();
      check("flow_frame_completes", int'(seen), 1);
      check("flow_no_new_read", rd_count[0] - rdc, 0);
      tx_en = 1'b1;
      lat = 0;
      for (int i = 1; i <= 5 && lat == 0; i++) begin
         cyc();
         if (fifo_rd[0]) lat = i;
      end
      check("reenable_read_latency_ok", int'(lat >= 1 && lat <= 2), 1);

      // Reset in the middle of data bit 3 of the 0x22 frame.
      fall_a = -1;
      for (int k = 0; k < 100 && fall_a < 0; k++) begin
         cyc();
         if (tx[0] == 1'b0) fall_a = cyc_no;
      end
      repeat (17) cyc();
      #1 reset = 1'b1;
      #1;
      check("async_reset_tx", int'(tx[0]), 1);
      check("async_reset_busy", int'(busy[0]), 0);
      repeat (2) cyc();
      reset = 1'b0;
      run_frame(0, got, fall_a, done_a);
      check("post_reset_bits", int'(got & 12'h3FF), int'({1'b1, 8'h33, 1'b0}));
      check("post_reset_done_offset", done_a - fall_a, 39);
      repeat (5) cyc();

      // Randomised traffic against the reference model.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(7) == 0) begin
            int d;
            d = int'($urandom_range(2));
            if (wp[d] - rp[d] < 50) push(d, 8'($urandom));
         end
         if ($urandom_range(63) == 0) tx_en = ~tx_en;
         cyc();
      end
      tx_en   = 1'b1;
      drained = 1'b0;
      for (int k = 0; k < 5000 && !drained; k++) begin
         cyc();
         drained = (wp[0] == rp[0]) && (wp[1] == rp[1]) && (wp[2] == rp[2]) &&
                   !m_busy[0] && !m_busy[1] && !m_busy[2];
      end
      check("random_drain_complete", int'(drained), 1);
      repeat (5) cyc();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_tx_fifo_drain.md
Name: uart_tx_fifo_drain

Overview:
- Downstream consumer of the 16x8 byte FIFO.
- Pulls bytes from the FIFO one at a time and serialises each as an asynchronous UART frame on `tx`: start bit, 8 data bits LSB first, optional parity, 1 or 2 stop bits.
- Generates the FIFO read strobe itself and samples FIFO read data with the fixed one-cycle read latency.
- Sits between the FIFO and the chip pad.

Parameters:
- CLKS_PER_BIT, 16, clk cycles per UART bit; legal range 2..65535.
- PARITY, 0, 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1, number of stop bits; 1 or 2.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high.
- tx_en  input  1  permits starting a new frame; sampled only in IDLE.
- fifo_empty  input  1  FIFO underflow/empty flag, registered in the FIFO.
- fifo_data  input  8  FIFO read data; valid exactly the cycle after fifo_rd.
- fifo_rd  output  1  single-cycle FIFO read strobe.
- tx  output  1  serial line; idles high.
- busy  output  1  high from REQ through the last stop-bit cycle.
- frame_done  output  1  one-cycle pulse in the final cycle of the last stop bit.

Behaviour:
- Reset (async, immediate):
  - Outputs: tx=1, fifo_rd=0, busy=0, frame_done=0.
  - Internal: state=IDLE, counters=0, shift register=0.
  - Reset mid-frame aborts the frame; tx returns high at once.
- All other logic updates on rising clk edge; all outputs are registered.
- States: IDLE, REQ, LOAD, START, DATA, PARITY, STOP.
- IDLE: tx=1. If tx_en=1 and fifo_empty=0, go to REQ with fifo_rd=1 in the REQ cycle.
- REQ: fifo_rd=1 for exactly this one cycle. Next state is LOAD.
- LOAD:
  - fifo_rd=0.
  - Capture fifo_data into the 8-bit shift register.
  - Compute parity bit: even = XOR of data; odd = inverted XOR.
  - Next state is START.
- Latency: fifo_rd high in cycle N; fifo_data sampled at the end of cycle N+1; tx falls at cycle N+2.
- START: tx=0 for CLKS_PER_BIT cycles.
- DATA:
  - tx = shift[0]; shift right by 1 at each bit boundary.
  - 3-bit index counts 0..7; after bit 7, go to PARITY if PARITY!=0, else STOP.
- PARITY: tx = parity bit for CLKS_PER_BIT cycles.
- STOP:
  - tx=1 for STOP_BITS*CLKS_PER_BIT cycles.
  - frame_done=1 in the final cycle.
  - Next state is IDLE.
- Baud counter:
  - Width clog2(CLKS_PER_BIT).
  - Counts 0..CLKS_PER_BIT-1; wraps to 0 at each bit boundary.
  - Cleared on entry to START.
- Frame length: (10 + (PARITY!=0) + (STOP_BITS-1)) * CLKS_PER_BIT cycles from tx falling edge to the end of the last stop bit.
- Back-to-back frames:
  - Minimum gap is one IDLE cycle plus REQ and LOAD, i.e. 3 cycles of tx=1 beyond the stop bits.
  - This gap also guarantees the FIFO's registered empty flag has settled before it is re-sampled.
- tx_en deasserted mid-frame: the current frame completes; no new read is issued.
- fifo_empty rising during REQ/LOAD: ignored. The read was already issued against a non-empty flag.
- fifo_rd is never asserted outside REQ, and never while fifo_empty=1 in the IDLE decision cycle.
- fifo_data is ignored in every cycle except LOAD.

Decomposition:
- Shared package uart_pkg:
  - state enumeration (IDLE..STOP, 3-bit encoding);
  - parity constants PAR_NONE=0, PAR_EVEN=1, PAR_ODD=2;
  - frame bit-count constant DATA_BITS=8.
- One sub-module, uart_baud_tick:
  - parameter CLKS_PER_BIT;
  - inputs clk, reset, clear;
  - output tick, a one-cycle pulse on the last cycle of each bit period.
- Bit-boundary logic in the FSM uses tick only.

Test Plan:
- Reset then idle: hold reset 3 cycles with fifo_empty=0, tx_en=1, release. Required: tx=1, fifo_rd=0 during reset; first fifo_rd in the cycle after the first IDLE cycle.
- Single byte, CLKS_PER_BIT=4, PARITY=0, fifo_data=0xA5 one cycle after fifo_rd.
  - tx bit sequence (4 cycles each): 0 | 1,0,1,0,0,1,0,1 | 1.
  - frame_done pulses once, 40 cycles after tx falls, minus 1.
- Parity on 0xA5:
  - PARITY=1 (even): parity bit 0.
  - PARITY=2 (odd): parity bit 1.
  - Frame is 44 cycles at CLKS_PER_BIT=4.
- Back-to-back: FIFO model holds 0x01, 0x80, with fifo_empty low until the second read.
  - Exactly two fifo_rd pulses.
  - Second start bit begins 3 cycles after the first frame's last stop cycle.
  - No third read after fifo_empty goes high.
- Flow control:
  - tx_en dropped during DATA of frame 1: frame completes, no further fifo_rd.
  - tx_en re-raised: next read issued within 2 cycles.
- Reset mid-frame: assert reset during DATA bit 3.
  - tx=1 and busy=0 immediately, without waiting for a clock edge.
  - After release, the next frame starts cleanly with a full start bit.
